// File: rtl/ddr_20g_pkg.sv
// ============================================================================
// Module      : ddr_20g_pkg
// Description : Shared constants, state encoding and beat-building helpers
//               for the DDR 20G test-pattern packet generator.
// Contents    : DATA_WD, HEAD_WD, LANE_NUM, LANE_WD, HEAD_FLAG, PKT_END_FLAG,
//               state_t, lane_vec(), head_beat()
// Options     : none (ERR_INJ_EN is consumed by ddr_20g_pkt_gen and
//               ddr_20g_pkt_gen_payload)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr_20g_pkg;

   localparam int DATA_WD  = 256;   // stream width, only 256 supported
   localparam int HEAD_WD  = 64;    // encoder word width in header beat
   localparam int LANE_NUM = 16;    // ADC lanes per payload beat
   localparam int LANE_WD  = 16;    // bits per ADC lane

   localparam logic [63:0]  HEAD_FLAG    = 64'hA5A5C3C3_A5A5C3C3;
   localparam logic [127:0] PKT_END_FLAG = 128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HEAD = 3'd1,
      ST_DATA = 3'd2,
      ST_TAIL = 3'd3,
      ST_GAP  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   // Lane k carries seed + k, wrapping modulo 2^16.
   function automatic logic [DATA_WD-1:0] lane_vec(input logic [LANE_WD-1:0] seed);
      logic [DATA_WD-1:0] v;
      v = '0;
      for (int k = 0; k < LANE_NUM; k++) begin
         v[k*LANE_WD +: LANE_WD] = seed + 16'(k);
      end
      return v;
   endfunction

   function automatic logic [DATA_WD-1:0] head_beat(input logic [HEAD_WD-1:0] enc,
                                                    input logic [15:0]        beats);
      return {112'd0, beats, HEAD_FLAG, enc};
   endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_20g_pkt_gen_payload.sv
// ============================================================================
// Module      : ddr_20g_pkt_gen_payload
// Description : ADC payload source. Holds the running adc_seed and presents
//               the lane vector of the next payload beat to be loaded into
//               the output register. The seed advances on every load.
// Options     : ERR_INJ_EN - adds i_err_inj / i_acc; a pulse arms a single
//               bit-0 inversion on the next payload beat emitted.
// Ports       : clk, rst_n   clock, asynchronous active-low reset
//               i_clr        synchronous clear (soft reset)
//               i_load       top is loading o_beat into its output register
//               i_acc        (ERR_INJ_EN) a payload beat was accepted
//               i_err_inj    (ERR_INJ_EN) error-injection request pulse
//               o_beat       payload beat for the current seed
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_20g_pkt_gen_payload
   import ddr_20g_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clr,
   input  logic               i_load,
`ifdef ERR_INJ_EN
   input  logic               i_acc,
   input  logic               i_err_inj,
`endif
   output logic [DATA_WD-1:0] o_beat
);

   logic [LANE_WD-1:0] r_seed;

   // The seed names the beat about to be loaded. Loads only happen when the
   // previous payload beat (or the header) is accepted, so this is the same
   // count as accepted payload beats for every packet that completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seed <= '0;
      end else if (i_clr) begin
         r_seed <= '0;
      end else if (i_load) begin
         r_seed <= r_seed + 16'(LANE_NUM);
      end
   end

`ifdef ERR_INJ_EN
   logic r_pend;     // injection requested, not yet delivered
   logic r_inj_out;  // beat currently on the output carries the injection
   logic w_inj;

   // Only inject when the beat on the output is not already the corrupted
   // one; otherwise a pulse during that beat would corrupt a second beat.
   assign w_inj = r_pend & ~r_inj_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend    <= 1'b0;
         r_inj_out <= 1'b0;
      end else if (i_clr) begin
         r_pend    <= 1'b0;
         r_inj_out <= 1'b0;
      end else begin
         r_pend <= (r_pend & ~(i_acc & r_inj_out)) | i_err_inj;
         if (i_load) begin
            r_inj_out <= w_inj;
         end else if (i_acc) begin
            r_inj_out <= 1'b0;
         end
      end
   end

   assign o_beat = lane_vec(r_seed) ^ {{(DATA_WD-1){1'b0}}, w_inj};
`else
   assign o_beat = lane_vec(r_seed);
`endif

endmodule

`default_nettype wire

// File: rtl/ddr_20g_pkt_gen.sv
// ============================================================================
// Module      : ddr_20g_pkt_gen
// Description : Test-pattern packet transmitter for the DDR 20G data path.
//               Emits header / ADC payload / end-flag framed packets on a
//               256-bit AXI-Stream with runtime packet count, length and gap.
// Options     : ERR_INJ_EN - adds input cfg_err_inj (single-beat payload
//               bit-0 corruption). Default build: port and logic absent.
// Ports       : clk, rst_n        clock, asynchronous active-low reset
//               cfg_rst           synchronous soft reset
//               cfg_en            run enable (level)
//               cfg_pkt_beats     payload beats per packet (0 -> 1)
//               cfg_gap           idle cycles between packets
//               cfg_pkt_num       packets per run (0 = unlimited)
//               cfg_err_inj       (ERR_INJ_EN) error-injection pulse
//               m_axis_*          256-bit stream master
//               pkt_cnt           packets completed (saturating)
//               busy, done        status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_20g_pkt_gen
   import ddr_20g_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_rst,
   input  logic               cfg_en,
   input  logic [15:0]        cfg_pkt_beats,
   input  logic [15:0]        cfg_gap,
   input  logic [31:0]        cfg_pkt_num,
`ifdef ERR_INJ_EN
   input  logic               cfg_err_inj,
`endif
   output logic [DATA_WD-1:0] m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic [31:0]        pkt_cnt,
   output logic               busy,
   output logic               done
);

   state_t               r_state;
   state_t               w_state_nxt;

   logic [DATA_WD-1:0]   r_tdata;
   logic                 r_tvalid;
   logic [31:0]          r_pkt_cnt;
   logic                 r_busy;
   logic                 r_done;
   logic [HEAD_WD-1:0]   r_enc_cnt;
   logic [15:0]          r_beats;      // sampled effective payload beats
   logic [15:0]          r_gap;        // sampled gap
   logic [31:0]          r_pkt_num;    // sampled quota
   logic [31:0]          r_run_cnt;    // packets completed in this run
   logic [15:0]          r_beat_cnt;   // payload beats loaded this packet
   logic [15:0]          r_gap_cnt;

   logic                 w_acc;
   logic [15:0]          w_eff_beats;
   logic [15:0]          w_hdr_beats;
   logic                 w_quota;
   logic                 w_sample;
   logic                 w_run_clr;
   logic                 w_ld_head;
   logic                 w_ld_pay;
   logic                 w_ld_tail;
   logic                 w_drop;
   logic                 w_hdr_acc;
   logic                 w_pay_acc;
   logic                 w_tail_acc;
   logic                 w_gap_ld;
   logic                 w_gap_dec;
   logic                 w_done_clr;
   logic                 w_busy_nxt;
   logic [DATA_WD-1:0]   w_pay_beat;

   assign w_acc       = r_tvalid & m_axis_tready;
   assign w_eff_beats = (cfg_pkt_beats == 16'd0) ? 16'd1 : cfg_pkt_beats;
   // Evaluated while the tail is on the output: would this tail fill the quota?
   assign w_quota     = (r_pkt_num != 32'd0) &&
                        (({1'b0, r_run_cnt} + 33'd1) >= {1'b0, r_pkt_num});
   assign w_busy_nxt  = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else if (cfg_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state / datapath controls. The state names the beat currently
   // on the output register; HEAD with tvalid low is the one-cycle entry
   // from IDLE, where the sampled config is turned into the header beat.
   // Packets following a tail or gap load their header on the same edge.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_hdr_beats = r_beats;
      w_sample    = 1'b0;
      w_run_clr   = 1'b0;
      w_ld_head   = 1'b0;
      w_ld_pay    = 1'b0;
      w_ld_tail   = 1'b0;
      w_drop      = 1'b0;
      w_hdr_acc   = 1'b0;
      w_pay_acc   = 1'b0;
      w_tail_acc  = 1'b0;
      w_gap_ld    = 1'b0;
      w_gap_dec   = 1'b0;
      w_done_clr  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cfg_en) begin
               w_state_nxt = ST_HEAD;
               w_sample    = 1'b1;
               w_run_clr   = 1'b1;
            end
         end
         ST_HEAD: begin
            if (!r_tvalid) begin
               w_ld_head = 1'b1;
            end else if (w_acc) begin
               w_state_nxt = ST_DATA;
               w_hdr_acc   = 1'b1;
               w_ld_pay    = 1'b1;
            end
         end
         ST_DATA: begin
            if (w_acc) begin
               w_pay_acc = 1'b1;
               if (r_beat_cnt == r_beats) begin
                  w_state_nxt = ST_TAIL;
                  w_ld_tail   = 1'b1;
               end else begin
                  w_ld_pay = 1'b1;
               end
            end
         end
         ST_TAIL: begin
            if (w_acc) begin
               w_tail_acc = 1'b1;
               if (r_gap != 16'd0) begin
                  w_state_nxt = ST_GAP;
                  w_gap_ld    = 1'b1;
                  w_drop      = 1'b1;
               end else if (w_quota) begin
                  w_state_nxt = ST_DONE;
                  w_drop      = 1'b1;
               end else if (cfg_en) begin
                  w_state_nxt = ST_HEAD;
                  w_sample    = 1'b1;
                  w_ld_head   = 1'b1;
                  w_hdr_beats = w_eff_beats;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_drop      = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (r_gap_cnt != 16'd0) begin
               w_gap_dec = 1'b1;
            end else if (r_done) begin
               w_state_nxt = ST_DONE;
            end else if (cfg_en) begin
               w_state_nxt = ST_HEAD;
               w_sample    = 1'b1;
               w_ld_head   = 1'b1;
               w_hdr_beats = w_eff_beats;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (!cfg_en) begin
               w_state_nxt = ST_IDLE;
               w_done_clr  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tdata    <= '0;
         r_tvalid   <= 1'b0;
         r_pkt_cnt  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_enc_cnt  <= '0;
         r_beats    <= 16'd1;
         r_gap      <= '0;
         r_pkt_num  <= '0;
         r_run_cnt  <= '0;
         r_beat_cnt <= '0;
         r_gap_cnt  <= '0;
      end else if (cfg_rst) begin
         r_tdata    <= '0;
         r_tvalid   <= 1'b0;
         r_pkt_cnt  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_enc_cnt  <= '0;
         r_beats    <= 16'd1;
         r_gap      <= '0;
         r_pkt_num  <= '0;
         r_run_cnt  <= '0;
         r_beat_cnt <= '0;
         r_gap_cnt  <= '0;
      end else begin
         if (w_sample) begin
            r_beats   <= w_eff_beats;
            r_gap     <= cfg_gap;
            r_pkt_num <= cfg_pkt_num;
         end

         if (w_run_clr) begin
            r_run_cnt <= '0;
         end else if (w_tail_acc && (r_run_cnt != '1)) begin
            r_run_cnt <= r_run_cnt + 32'd1;
         end

         if (w_hdr_acc) begin
            r_enc_cnt <= r_enc_cnt + 64'd1;
         end

         if (w_hdr_acc) begin
            r_beat_cnt <= 16'd1;
         end else if (w_pay_acc) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
         end

         if (w_gap_ld) begin
            r_gap_cnt <= r_gap - 16'd1;
         end else if (w_gap_dec) begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
         end

         if (w_ld_head) begin
            r_tdata  <= head_beat(r_enc_cnt, w_hdr_beats);
            r_tvalid <= 1'b1;
         end else if (w_ld_pay) begin
            r_tdata  <= w_pay_beat;
            r_tvalid <= 1'b1;
         end else if (w_ld_tail) begin
            r_tdata  <= {PKT_END_FLAG, PKT_END_FLAG};
            r_tvalid <= 1'b1;
         end else if (w_drop) begin
            r_tvalid <= 1'b0;
         end

         if (w_tail_acc && (r_pkt_cnt != '1)) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
         end

         if (w_tail_acc && w_quota) begin
            r_done <= 1'b1;
         end else if (w_done_clr) begin
            r_done <= 1'b0;
         end

         r_busy <= w_busy_nxt;
      end
   end

   ddr_20g_pkt_gen_payload u_payload (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (cfg_rst),
      .i_load    (w_ld_pay),
`ifdef ERR_INJ_EN
      .i_acc     (w_pay_acc),
      .i_err_inj (cfg_err_inj),
`endif
      .o_beat    (w_pay_beat)
   );

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign pkt_cnt       = r_pkt_cnt;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ddr_20g_pkt_gen.sv
// ============================================================================
// Module      : tb_ddr_20g_pkt_gen
// Description : Self-checking bench for ddr_20g_pkt_gen. A packet-level model
//               builds the expected beat stream; a monitor compares accepted
//               beats, hold-stability under back-pressure, gap lengths and
//               status outputs. ERR_INJ_EN adds the error-injection case.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ddr_20g_pkt_gen;

   logic          clk;
   logic          rst_n;
   logic          cfg_rst;
   logic          cfg_en;
   logic [15:0]   cfg_pkt_beats;
   logic [15:0]   cfg_gap;
   logic [31:0]   cfg_pkt_num;
`ifdef ERR_INJ_EN
   logic          cfg_err_inj;
`endif
   logic [255:0]  m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [31:0]   pkt_cnt;
   logic          busy;
   logic          done;

   ddr_20g_pkt_gen u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_rst       (cfg_rst),
      .cfg_en        (cfg_en),
      .cfg_pkt_beats (cfg_pkt_beats),
      .cfg_gap       (cfg_gap),
      .cfg_pkt_num   (cfg_pkt_num),
`ifdef ERR_INJ_EN
      .cfg_err_inj   (cfg_err_inj),
`endif
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .pkt_cnt       (pkt_cnt),
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- state
   int            n_chk;
   int            n_err;
   int            cyc;
   int            rdy_mode;       // 0: ready always high, 1: random 50 %
   logic [255:0]  exp_q[$];       // expected beats in order
   bit            kind_q[$];      // 1 = tail beat
   int            acc_cyc_q[$];   // cycle index of every accepted beat
   int            tail_cyc_q[$];  // cycle index of every accepted tail
   int            rise_q[$];      // cycle index of every tvalid rise
   logic [63:0]   m_enc;
   logic [15:0]   m_seed;
   bit            m_inj;
   bit            prev_valid;
   bit            stall_prev;
   logic [255:0]  prev_data;
   logic [31:0]   exp_pkt;

   task automatic check_value(input string tag, input logic [255:0] obs,
                              input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: appends one whole packet to the expected stream.
   task automatic model_packet(input int beats);
      int           eff;
      logic [255:0] b;
      eff = (beats == 0) ? 1 : beats;
      b = '0;
      b[63:0]    = m_enc;
      b[127:64]  = 64'hA5A5C3C3A5A5C3C3;
      b[143:128] = eff[15:0];
      exp_q.push_back(b);
      kind_q.push_back(1'b0);
      m_enc = m_enc + 64'd1;
      for (int i = 0; i < eff; i++) begin
         for (int k = 0; k < 16; k++) begin
            b[k*16 +: 16] = m_seed + 16'(k);
         end
         if (m_inj) begin
            b[0]  = ~b[0];
            m_inj = 1'b0;
         end
         exp_q.push_back(b);
         kind_q.push_back(1'b0);
         m_seed = m_seed + 16'd16;
      end
      b = {2{128'h5A5ADEAD0000FFFF5A5ADEAD0000FFFF}};
      exp_q.push_back(b);
      kind_q.push_back(1'b1);
   endtask

   task automatic model_reset();
      exp_q.delete();
      kind_q.delete();
      m_enc   = '0;
      m_seed  = '0;
      m_inj   = 1'b0;
      exp_pkt = '0;
   endtask

   // One clock: sample at the falling edge, check, then drive tready.
   task automatic tick();
      bit           acc;
      logic [255:0] e;
      bit           t;
      @(negedge clk);
      cyc++;
      if (stall_prev) begin
         check_value("hold_valid", 256'(m_axis_tvalid), 256'd1);
         check_value("hold_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = m_axis_tvalid;
      if (rdy_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
      else               m_axis_tready = 1'b1;
      acc        = m_axis_tvalid && m_axis_tready;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      if (acc) begin
         acc_cyc_q.push_back(cyc);
         check_value("beat_expected", 256'(exp_q.size() != 0), 256'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = kind_q.pop_front();
            check_value("beat_data", m_axis_tdata, e);
            if (t) tail_cyc_q.push_back(cyc);
         end
      end
   endtask

   // One complete run from IDLE with a packet quota, then cfg_en dropped.
   task automatic run_cfg(input int beats, input int gap, input int num, input int mode);
      int t0, r0, a0, eff, budget, nbeat;
      cfg_pkt_beats = 16'(beats);
      cfg_gap       = 16'(gap);
      cfg_pkt_num   = 32'(num);
      rdy_mode      = mode;
      eff           = (beats == 0) ? 1 : beats;
      nbeat         = num * (eff + 2);
      for (int p = 0; p < num; p++) model_packet(beats);
      t0 = tail_cyc_q.size();
      r0 = rise_q.size();
      a0 = acc_cyc_q.size();
      cfg_en = 1'b1;
      tick();
      check_value("hdr_lat_edge1", 256'(m_axis_tvalid), 256'd0);
      tick();
      check_value("hdr_lat_edge2", 256'(m_axis_tvalid), 256'd1);
      budget = num * (eff + 2 + gap) * 8 + 50;
      for (int i = 0; i < budget && !(done && !busy); i++) tick();
      exp_pkt = exp_pkt + 32'(num);
      check_value("run_done", 256'(done), 256'd1);
      check_value("run_busy", 256'(busy), 256'd0);
      check_value("run_pkt_cnt", 256'(pkt_cnt), 256'(exp_pkt));
      check_value("run_beats_left", 256'(exp_q.size()), 256'd0);
      check_value("run_beat_count", 256'(acc_cyc_q.size() - a0), 256'(nbeat));
      if (gap == 0) begin
         check_value("run_valid_rises", 256'(rise_q.size() - r0), 256'd1);
         if (mode == 0 && acc_cyc_q.size() >= a0 + nbeat)
            check_value("run_back_to_back",
                        256'(acc_cyc_q[a0 + nbeat - 1] - acc_cyc_q[a0]),
                        256'(nbeat - 1));
      end else begin
         check_value("run_valid_rises", 256'(rise_q.size() - r0), 256'(num));
         for (int k = 0; k + 1 < num; k++) begin
            if (rise_q.size() > r0 + k + 1 && tail_cyc_q.size() > t0 + k)
               check_value("gap_cycles",
                           256'(rise_q[r0 + k + 1] - tail_cyc_q[t0 + k] - 1),
                           256'(gap));
         end
      end
      cfg_en = 1'b0;
      tick();
      tick();
      check_value("stop_done", 256'(done), 256'd0);
      check_value("stop_busy", 256'(busy), 256'd0);
   endtask

   initial begin
      int a0;
      n_chk = 0; n_err = 0; cyc = 0; rdy_mode = 0;
      prev_valid = 1'b0; stall_prev = 1'b0; prev_data = '0;
      model_reset();
      rst_n = 1'b0; cfg_rst = 1'b0; cfg_en = 1'b0;
      cfg_pkt_beats = '0; cfg_gap = '0; cfg_pkt_num = '0;
      m_axis_tready = 1'b1;
`ifdef ERR_INJ_EN
      cfg_err_inj = 1'b0;
`endif
      repeat (3) tick();
      check_value("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
      check_value("rst_tdata", m_axis_tdata, 256'd0);
      check_value("rst_pkt_cnt", 256'(pkt_cnt), 256'd0);
      check_value("rst_busy", 256'(busy), 256'd0);
      check_value("rst_done", 256'(done), 256'd0);
      rst_n = 1'b1;
      tick();

      // Basic quota run: 3 packets of 4 beats, no gap.
      run_cfg(4, 0, 3, 0);

      // Soft reset then the same run under random back-pressure.
      cfg_rst = 1'b1;
      tick();
      cfg_rst = 1'b0;
      model_reset();
      check_value("softrst_pkt_cnt", 256'(pkt_cnt), 256'd0);
      run_cfg(4, 0, 3, 1);

      // Inter-packet gap.
      run_cfg(3, 5, 3, 0);

      // Randomised configurations (beats 0 exercises the 0 -> 1 rule).
      for (int r = 0; r < 4; r++) begin
         run_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                 int'($urandom_range(1, 4)), 1);
      end

      // cfg_en dropped during payload beat 2 of an 8-beat unlimited run.
      cfg_pkt_beats = 16'd8; cfg_gap = 16'd2; cfg_pkt_num = 32'd0; rdy_mode = 0;
      model_packet(8);
      a0 = acc_cyc_q.size();
      cfg_en = 1'b1;
      for (int i = 0; i < 30 && acc_cyc_q.size() < a0 + 3; i++) tick();
      cfg_en = 1'b0;
      for (int i = 0; i < 60 && busy; i++) tick();
      repeat (6) tick();
      exp_pkt = exp_pkt + 32'd1;
      check_value("endrop_beats_left", 256'(exp_q.size()), 256'd0);
      check_value("endrop_busy", 256'(busy), 256'd0);
      check_value("endrop_tvalid", 256'(m_axis_tvalid), 256'd0);
      check_value("endrop_pkt_cnt", 256'(pkt_cnt), 256'(exp_pkt));
      check_value("endrop_done", 256'(done), 256'd0);

      // Soft reset in the middle of the payload, then restart from zero.
      cfg_pkt_beats = 16'd8; cfg_gap = 16'd0; cfg_pkt_num = 32'd0;
      model_packet(8);
      a0 = acc_cyc_q.size();
      cfg_en = 1'b1;
      for (int i = 0; i < 30 && acc_cyc_q.size() < a0 + 4; i++) tick();
      cfg_rst = 1'b1;
      cfg_en  = 1'b0;
      tick();
      cfg_rst = 1'b0;
      check_value("midrst_tvalid", 256'(m_axis_tvalid), 256'd0);
      check_value("midrst_pkt_cnt", 256'(pkt_cnt), 256'd0);
      check_value("midrst_busy", 256'(busy), 256'd0);
      model_reset();
      run_cfg(2, 1, 2, 0);

`ifdef ERR_INJ_EN
      // Two pulses while idle collapse into one corrupted payload beat.
      cfg_err_inj = 1'b1; tick(); cfg_err_inj = 1'b0; tick();
      cfg_err_inj = 1'b1; tick(); cfg_err_inj = 1'b0; tick();
      m_inj = 1'b1;
      run_cfg(3, 0, 2, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
